// File: rtl/inst_mem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : inst_loader_pkg                                            |
// | Description : Shared types and constants for the instruction-memory      |
// |               loader: FSM state encoding, memory geometry and the        |
// |               length-byte validity check.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package inst_loader_pkg;

  localparam int INST_ADDR_W = 6;
  localparam int INST_DEPTH  = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // A word count is usable when it is non-zero and fits in the memory.
  // The count is treated as an 8-bit unsigned value.
  function automatic logic len_ok(input logic [7:0] n, input int depth);
    return (n != 8'd0) && (32'(n) <= 32'(depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : inst_mem_loader_if                                         |
// | Description : Byte-stream handshake (valid/ready) into the loader and    |
// |               the synchronous instruction-memory write port out of it.   |
// |   byte_valid / byte_data : stream source -> loader                       |
// |   byte_ready             : loader -> stream source                       |
// |   wr_en/wr_addr/wr_data  : loader -> instruction memory                  |
// |   modport slave  : loader view                                           |
// |   modport master : source / memory view                                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface inst_mem_loader_if
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

endinterface
`default_nettype wire

// File: rtl/inst_mem_loader_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_word_packer                                           |
// | Description : Assembles four stream bytes into a 32-bit little-endian    |
// |               word. Byte number byte_cnt lands in bits                   |
// |               [8*byte_cnt +: 8]; byte_cnt wraps 3 -> 0.                  |
// |   clk, rst  : clock, asynchronous active-high reset                      |
// |   clear     : zero the buffer and byte counter                           |
// |   shift_en  : accept byte_in at the current byte position                |
// |   byte_in   : incoming stream byte                                       |
// |   word      : buffer contents including the byte accepted this cycle     |
// |   last_byte : current position is byte 3 (a shift completes a word)      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module inst_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] buf_q, buf_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    if (clear) begin
      byte_cnt_d = 2'd0;
      buf_d      = 32'd0;
    end else if (shift_en) begin
      buf_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      buf_q      <= 32'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
    end
  end

  // Exposing the next buffer value lets the caller capture the completed
  // word on the same edge that accepts its fourth byte.
  assign word      = buf_d;
  assign last_byte = (byte_cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_mem_loader                                            |
// | Description : Loads a program into instruction memory from a byte        |
// |               stream. Byte 0 is the word count N (1..DEPTH), followed    |
// |               by 4*N bytes, LSB first. Words go to addresses 0..N-1.     |
// |               The CPU is held in reset for the whole session.            |
// |   clk, rst  : clock, asynchronous active-high reset                      |
// |   start     : begin a session (sampled in IDLE only)                     |
// |   bus       : byte handshake in, memory write port out                   |
// |   cpu_hold  : hold CPU in reset while busy                               |
// |   busy      : session in progress                                        |
// |   done      : one-cycle pulse after the last word is written             |
// |   err       : sticky bad-length flag, cleared by the next start          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  inst_mem_loader_if.slave   bus,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        n_q, n_d;
  // One extra bit so a full-depth load counts up to DEPTH without wrapping.
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic              byte_ready;
  logic              xfer;
  logic              pk_clear;
  logic              pk_shift;
  logic [31:0]       pk_word;
  logic              pk_last;

  // Ready depends only on registered state, never on byte_valid.
  assign byte_ready = (state_q == LEN) || (state_q == DATA);
  assign xfer       = bus.byte_valid && byte_ready;

  inst_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .byte_in   (bus.byte_data),
    .word      (pk_word),
    .last_byte (pk_last)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pk_clear   = 1'b0;
    pk_shift   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LEN;
          err_d      = 1'b0;
          word_cnt_d = '0;
          pk_clear   = 1'b1;
        end
      end

      LEN: begin
        if (xfer) begin
          n_d = bus.byte_data;
          if (len_ok(bus.byte_data, DEPTH)) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end

      DATA: begin
        if (xfer) begin
          pk_shift = 1'b1;
          if (pk_last) begin
            // Write-port registers load here so they are valid, and then
            // held, from the WRITE cycle onward.
            state_d   = WRITE;
            wr_addr_d = word_cnt_q[ADDR_W-1:0];
            wr_data_d = pk_word;
          end
        end
      end

      WRITE: begin
        word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        if ((32'(word_cnt_q) + 32'd1) == 32'(n_q)) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= 8'd0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = (state_q == WRITE);
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign busy           = (state_q != IDLE);
  assign cpu_hold       = busy;
  assign done           = (state_q == DONE);
  assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_inst_mem_loader                                         |
// | Description : Self-checking bench for inst_mem_loader. A transaction-    |
// |               level model predicts every output each cycle from the      |
// |               observed handshakes; directed scenarios pin cycle counts   |
// |               and memory contents with literal values.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_inst_mem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, busy, done, err;

  inst_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model + memory image ----------------
  logic [31:0]       mem [DEPTH];
  bit                m_busy, m_wr_now, m_done_now, m_err, m_got_len;
  int                m_n, m_bytes, m_widx;
  logic [31:0]       m_buf;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [31:0]       m_wr_data;
  int                wr_cnt = 0, done_cnt = 0;
  int                t_start, t_wr, t_done, t_idle;
  bit                busy_prev = 1'b0;

  always @(negedge clk) begin
    bit nb, nw, nd;
    if (rst) begin
      check("rst_byte_ready", 32'(bus.byte_ready), 0);
      check("rst_wr_en",      32'(bus.wr_en), 0);
      check("rst_wr_addr",    32'(bus.wr_addr), 0);
      check("rst_wr_data",    bus.wr_data, 0);
      check("rst_cpu_hold",   32'(cpu_hold), 0);
      check("rst_busy",       32'(busy), 0);
      check("rst_done",       32'(done), 0);
      check("rst_err",        32'(err), 0);
      m_busy = 0; m_wr_now = 0; m_done_now = 0; m_err = 0;
      m_wr_addr = '0; m_wr_data = 32'd0;
    end else begin
      check("cpu_hold",   32'(cpu_hold), 32'(m_busy));
      check("busy",       32'(busy), 32'(m_busy));
      check("byte_ready", 32'(bus.byte_ready), 32'(m_busy && !m_wr_now && !m_done_now));
      check("wr_en",      32'(bus.wr_en), 32'(m_wr_now));
      check("wr_addr",    32'(bus.wr_addr), 32'(m_wr_addr));
      check("wr_data",    bus.wr_data, m_wr_data);
      check("done",       32'(done), 32'(m_done_now));
      check("err",        32'(err), 32'(m_err));

      if (bus.wr_en) begin mem[bus.wr_addr] = bus.wr_data; wr_cnt++; t_wr = cyc; end
      if (done) begin done_cnt++; t_done = cyc; end
      if (busy_prev && !busy) t_idle = cyc;

      // Predict next cycle from what was observed this cycle.
      nb = m_busy; nw = 0; nd = 0;
      if (!m_busy) begin
        if (start) begin
          nb = 1; m_err = 0; m_got_len = 0; m_bytes = 0; m_widx = 0; t_start = cyc;
        end
      end else if (m_done_now) begin
        nb = 0;
      end else if (m_wr_now) begin
        if (m_widx == m_n) nd = 1;
      end else if (bus.byte_valid) begin
        if (!m_got_len) begin
          m_got_len = 1;
          m_n = int'(bus.byte_data);
          if (m_n < 1 || m_n > DEPTH) begin m_err = 1; nb = 0; end
        end else begin
          m_buf[(m_bytes % 4) * 8 +: 8] = bus.byte_data;
          m_bytes++;
          if (m_bytes % 4 == 0) begin
            nw = 1; m_wr_addr = ADDR_W'(m_widx); m_wr_data = m_buf; m_widx++;
          end
        end
      end
      m_busy = nb; m_wr_now = nw; m_done_now = nd;
    end
    busy_prev = busy;
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok = 0;
    if (gap && ($urandom_range(0, 1) == 1)) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.byte_ready) begin ok = 1; break; end
    end
    check("send_timeout", 32'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int b = 0; b < 4; b++) send_byte(w[b*8 +: 8], gap);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    bus.byte_valid = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("idle_timeout", 32'(ok), 1);
    @(posedge clk); #1;
  endtask

  logic [31:0] demo [7];
  logic [31:0] img  [DEPTH];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wb, db;
    logic [31:0] wa, wbw;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    demo[0] = 32'h00402083; demo[1] = 32'h00802103; demo[2] = 32'h002081B3;
    demo[3] = 32'h00302423; demo[4] = 32'h00000013; demo[5] = 32'h00000013;
    demo[6] = 32'h0000006F;

    rst = 1'b1; start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // N=1, valid held high
    pulse_start();
    send_byte(8'd1, 0);
    send_word(32'h00402083, 0);
    wait_idle();
    check("n1_wr_cycle",   32'(t_wr - t_start), 6);
    check("n1_done_cycle", 32'(t_done - t_start), 7);
    check("n1_hold_fall",  32'(t_idle - t_start), 8);
    check("n1_mem0",       mem[0], 32'h00402083);

    // N=7 demo program, valid held high
    pulse_start();
    send_byte(8'd7, 0);
    for (int i = 0; i < 7; i++) send_word(demo[i], 0);
    wait_idle();
    check("n7_done_cycle", 32'(t_done - t_start), 37);
    for (int i = 0; i < 7; i++) check("n7_mem", mem[i], demo[i]);

    // N=64 random words, randomly stalled stream
    db = done_cnt; wb = wr_cnt;
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    pulse_start();
    send_byte(8'd64, 1);
    for (int i = 0; i < DEPTH; i++) send_word(img[i], 1);
    wait_idle();
    check("n64_done_once", 32'(done_cnt - db), 1);
    check("n64_writes",    32'(wr_cnt - wb), 64);
    for (int i = 0; i < DEPTH; i++) check("n64_mem", mem[i], img[i]);

    // Invalid lengths 0 and 65
    wb = wr_cnt;
    pulse_start();
    send_byte(8'd0, 0);
    wait_idle();
    check("n0_err", 32'(err), 1);
    pulse_start();
    check("err_clear_on_start", 32'(err), 0);
    send_byte(8'd65, 0);
    wait_idle();
    check("n65_err", 32'(err), 1);
    check("bad_len_no_write", 32'(wr_cnt - wb), 0);
    pulse_start();
    check("err_clear_on_start2", 32'(err), 0);
    send_byte(8'd1, 0);
    send_word(32'hCAFEF00D, 0);
    wait_idle();
    check("after_err_mem0", mem[0], 32'hCAFEF00D);

    // Reset after the 6th data byte of an N=3 load
    wa = 32'h11223344; wbw = 32'h55667788;
    wb = wr_cnt;
    pulse_start();
    send_byte(8'd3, 0);
    send_word(wa, 0);
    send_byte(wbw[7:0], 0);
    send_byte(wbw[15:8], 0);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_mid_writes", 32'(wr_cnt - wb), 1);
    check("rst_mid_mem0", mem[0], wa);
    check("rst_mid_idle", 32'(busy), 0);
    pulse_start();
    send_byte(8'd2, 0);
    send_word(32'hA5A5_0001, 0);
    send_word(32'h5A5A_0002, 0);
    wait_idle();
    check("reload_mem0", mem[0], 32'hA5A5_0001);
    check("reload_mem1", mem[1], 32'h5A5A_0002);

    // start pulsed during DATA is ignored
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_word(32'hDEADBEEF, 0);
    wait_idle();
    check("start_in_data_mem0", mem[0], 32'h04030201);
    check("start_in_data_mem1", mem[1], 32'hDEADBEEF);

    // start coincident with byte_valid in IDLE: that byte must wait for LEN
    @(posedge clk); #1;
    start = 1'b1; bus.byte_valid = 1'b1; bus.byte_data = 8'd2;
    @(posedge clk); #1 start = 1'b0;
    send_byte(8'd2, 0);
    send_word(32'h0BADC0DE, 0);
    send_word(32'h12345678, 0);
    wait_idle();
    check("coincident_done_cycle", 32'(t_done - t_start), 12);
    check("coincident_mem0", mem[0], 32'h0BADC0DE);
    check("coincident_mem1", mem[1], 32'h12345678);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writer side of the instruction memory. Receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words. Writes each word into consecutive instruction-memory word addresses starting at 0. While loading, it holds the CPU in reset, so the core only fetches from a fully written image.

## Interface
Parameters:
- ADDR_W, 6: instruction-memory word-address width; DEPTH = 2**ADDR_W (64 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a load session; sampled only in IDLE.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  holds the CPU in reset while a session is in progress.
- busy  out  1  session in progress; same value as cpu_hold.
- done  out  1  one-cycle pulse after the last word is written.
- err  out  1  sticky length error; cleared by the next accepted start or by rst.

## Operation
- Stream format: byte 0 is the word count N. Then 4·N instruction bytes follow, least-significant byte first.
- Valid N is 1..DEPTH. N = 0 or N > DEPTH is an error.
- States and transitions:
  - IDLE: start=1 → LEN; clear err, word counter and byte counter.
  - LEN: byte_ready=1. On transfer, latch N.
    - If N is valid → DATA.
    - Otherwise → IDLE with err=1; no memory write occurs.
  - DATA: byte_ready=1. Each transfer shifts the byte into byte position byte_cnt of the word buffer. byte_cnt is 2 bits and wraps 3→0. The transfer with byte_cnt=3 → WRITE.
  - WRITE: byte_ready=0. wr_en=1, wr_addr=word_cnt, wr_data=buffer. Then increment word_cnt.
    - If word_cnt+1 == N → DONE.
    - Otherwise → DATA.
  - DONE: done=1 for one cycle → IDLE.
- Width rules:
  - N is compared as 8-bit unsigned against DEPTH.
  - word_cnt is ADDR_W+1 bits wide, so N = DEPTH terminates without wrap.
  - wr_addr is word_cnt[ADDR_W-1:0].
- Outputs:
  - cpu_hold = busy = 1 in LEN, DATA, WRITE and DONE; 0 in IDLE.
  - wr_data and wr_addr hold their last values when wr_en=0.
- Boundary conditions:
  - start while not IDLE is ignored.
  - byte_valid stalls (valid low) in any state: the loader waits indefinitely and no timeout exists.
  - start and byte_valid in the same IDLE cycle: the byte is not accepted, because byte_ready=0 in IDLE.
  - rst mid-session:
    - All state returns to IDLE.
    - Outputs go to reset values.
    - Words already written stay in memory; the loader does not clear memory.
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, err=0.

## Timing
- Cycle 0: start sampled. Cycle 1: state LEN, byte_ready=1.
- With byte_valid held high:
  - Length byte is accepted in cycle 1.
  - Word k's bytes are accepted in cycles 2+5k .. 5+5k.
  - Word k's wr_en is high in cycle 6+5k.
- done is high in cycle 2+5N. cpu_hold falls in cycle 3+5N.
- err rises the cycle after an invalid length byte is accepted.
- Write latency: one cycle from acceptance of a word's 4th byte to its wr_en.
- All outputs are registered or decoded from registered state. There is no combinational path from byte_valid to byte_ready.

## Structure
- Shared package `inst_loader_pkg`:
  - state enum: IDLE, LEN, DATA, WRITE, DONE.
  - INST_ADDR_W = 6.
  - INST_DEPTH = 64.
- Sub-module `inst_word_packer`:
  - Function: 4-byte little-endian shift/assemble register with byte_cnt.
  - Inputs: shift enable, clear.
  - Outputs: word, last_byte flag.
- Top level: FSM, word counter, length check and write port.
- The instruction memory gains a synchronous write port (wr_en, wr_addr, wr_data) alongside its existing asynchronous read port.

## Test plan
- N=1, bytes 83 20 40 00 with valid held high → wr_en in cycle 6, wr_addr=0, wr_data=0x00402083. done in cycle 7. cpu_hold high in cycles 1–7.
- N=7 with the seven-instruction demo program (first word 0x00402083, lw x1,4(x0)) → addresses 0..6 written in order. Memory readback matches. done in cycle 37.
- N=64, random words, and byte_valid toggling randomly → all 64 words correct. word_cnt does not wrap early. done asserted exactly once.
- N=0, then separately N=65 → err=1 the following cycle. No wr_en. Return to IDLE. err clears on the next start.
- rst asserted after the 6th data byte of an N=3 load → next cycle all outputs at reset values. Word 0 stays written. A new start reloads correctly.
- start pulsed in DATA, and start coincident with byte_valid in IDLE → both ignored. No extra byte is consumed.
